burst_feeder: RTL and testbench

- Read-side data source for the input-buffer `sender`. Fetches words from a source SRAM/DRAM-model port and emits fixed-length bursts on the `rvalid`/`rdata` interface that `sender` consumes.
- Burst k covers words `start_addr + k*step` through `start_addr + k*step + BURST-1`, modulo 2^AW. Bursts are separated by a fixed idle gap.
- Sits between the external-memory model/controller and `sender`. The `rvalid`/`rdata` timing it produces is the timing `sender` is specified against.

---
 rtl/burst_feeder_if.sv | 31 +++
 rtl/burst_feeder.sv | 165 ++++++++++++++++
 tb/tb_burst_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/burst_feeder_if.sv
// Bundle shared by burst_feeder, its source memory port and the downstream sender.
// master = burst_feeder itself, slave = the environment (memory model, sender, controller).
interface burst_feeder_if #(
  parameter int DW   = 32,
  parameter int AW   = 10,
  parameter int NB_W = 16
);
  logic            data_load;
  logic [AW-1:0]   start_addr;
  logic [AW-1:0]   step;
  logic [NB_W-1:0] num_bursts;
  logic            mem_ren;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  // rvalid has no ready: sender must take rdata on every cycle rvalid is high.
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            done;
  logic [2:0]      fsm_state;

  modport master (
    input  data_load, start_addr, step, num_bursts, mem_rdata,
    output mem_ren, mem_addr, rvalid, rdata, busy, done, fsm_state
  );

  modport slave (
    output data_load, start_addr, step, num_bursts, mem_rdata,
    input  mem_ren, mem_addr, rvalid, rdata, busy, done, fsm_state
  );
endinterface

// File: rtl/burst_feeder.sv
// Fetches fixed-length bursts from a 1-cycle-latency source memory and streams them to sender.
// Optional BURST_FEEDER_STALL_EN adds a stall input that can extend the inter-burst gap.
module burst_feeder #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int BURST = 32,
  parameter int GAP   = 9,
  parameter int LEAD  = 6,
  parameter int NB_W  = 16
) (
  input logic            clk,
  input logic            rst,
`ifdef BURST_FEEDER_STALL_EN
  input logic            stall,
`endif
  burst_feeder_if.master bus
);
  localparam int CMAX = (BURST > GAP) ? ((BURST > LEAD) ? BURST : LEAD)
                                      : ((GAP > LEAD) ? GAP : LEAD);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LEAD_LAST  = CW'(LEAD - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_RD    = 3'd2,
    S_GAP   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   base;
  logic [AW-1:0]   step_q;
  logic [NB_W-1:0] left;
  logic            load_q;
  logic            ren_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic            busy_q;
  logic            done_q;
  logic            mem_ren_c;
  logic [AW-1:0]   mem_addr_c;
  logic            trigger;
  logic            abort;
  logic            stall_hold;
  logic            finish;

  // A rising edge in the done cycle is swallowed so a completed run cannot chain.
  assign trigger = bus.data_load && !load_q && (state == S_IDLE) && !done_q;
  assign abort   = !bus.data_load &&
                   ((state == S_LEAD) || (state == S_RD) || (state == S_GAP));
  assign finish  = (state == S_FLUSH) && (state_nxt == S_IDLE);

`ifdef BURST_FEEDER_STALL_EN
  assign stall_hold = stall;
`else
  assign stall_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      base     <= '0;
      step_q   <= '0;
      left     <= '0;
      // Tracks the pin through reset so a level held high across reset is not an edge.
      load_q   <= bus.data_load;
      ren_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      load_q <= bus.data_load;
      if ((state_nxt != state) || (state == S_IDLE) || (state == S_FLUSH)) begin
        cnt <= '0;
      end else if (!((state == S_GAP) && (cnt == GAP_LAST))) begin
        cnt <= cnt + CW'(1);
      end
      if (trigger) begin
        base   <= bus.start_addr;
        step_q <= bus.step;
        left   <= bus.num_bursts;
      end else if ((state == S_RD) && (state_nxt == S_GAP)) begin
        left <= left - NB_W'(1);
      end else if ((state == S_GAP) && (state_nxt == S_RD)) begin
        base <= base + step_q;
      end
      // Abort kills the words already requested from memory.
      ren_q    <= mem_ren_c && !abort;
      rvalid_q <= ren_q && !abort;
      if (ren_q && !abort) begin
        rdata_q <= bus.mem_rdata;
      end
      if (trigger) begin
        busy_q <= 1'b1;
      end else if (abort || finish) begin
        busy_q <= 1'b0;
      end
      done_q <= finish;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          state_nxt = (bus.num_bursts == '0) ? S_FLUSH : S_LEAD;
        end
      end
      S_LEAD: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == LEAD_LAST) begin
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == BURST_LAST) begin
          state_nxt = (left == NB_W'(1)) ? S_FLUSH : S_GAP;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if ((cnt == GAP_LAST) && !stall_hold) begin
          state_nxt = S_RD;
        end
      end
      S_FLUSH: begin
        // Last request has left ren_q, so its word is on rvalid this cycle.
        if (!ren_q) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ren_c  = 1'b0;
    mem_addr_c = '0;
    if (state == S_RD) begin
      mem_ren_c  = 1'b1;
      mem_addr_c = base + AW'(cnt);
    end
  end

  assign bus.mem_ren   = mem_ren_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_burst_feeder.sv
// Directed bench for burst_feeder: word[i]=i memory model, expected-word queue, timing checks.
module tb_burst_feeder;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB_W = 16;
  localparam int BURST = 32;

  logic clk;
  logic rst;
`ifdef BURST_FEEDER_STALL_EN
  logic stall;
`endif

  burst_feeder_if #(.DW(DW), .AW(AW), .NB_W(NB_W)) bus ();

  burst_feeder #(
    .DW(DW), .AW(AW), .BURST(BURST), .GAP(9), .LEAD(6), .NB_W(NB_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef BURST_FEEDER_STALL_EN
    .stall(stall),
`endif
    .bus  (bus.master)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // source memory: word[i] = i, one cycle latency
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= DW'(bus.mem_addr);
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int gap_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int rv_cnt, ren_cnt, done_cnt;
  int first_rv, last_rv, done_cyc, trig_cyc;
  logic done_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid) begin
        if (rv_cnt == 0) first_rv = cyc;
        else if (cyc != last_rv + 1) gap_q.push_back(cyc - last_rv - 1);
        last_rv = cyc;
        rv_cnt++;
        if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else check("rdata", bus.rdata, exp_q.pop_front());
      end
      if (bus.mem_ren) ren_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_busy = bus.busy;
      end
    end
  end

  // driver tasks
  task automatic clear_stats();
    rv_cnt = 0; ren_cnt = 0; done_cnt = 0;
    first_rv = -1; last_rv = -1; done_cyc = -1; done_busy = 1'b1;
    exp_q.delete();
    gap_q.delete();
  endtask

  task automatic push_expected(input logic [AW-1:0] sa, input logic [AW-1:0] st,
                               input int nb, input int words);
    logic [AW-1:0] a;
    int k;
    k = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < BURST; j++) begin
        a = sa + AW'(b) * st + AW'(j);
        if (k < words) exp_q.push_back(DW'(a));
        k++;
      end
    end
  endtask

  task automatic start_run(input logic [AW-1:0] sa, input logic [AW-1:0] st,
                           input logic [NB_W-1:0] nb);
    @(posedge clk); #1;
    bus.start_addr = sa;
    bus.step = st;
    bus.num_bursts = nb;
    bus.data_load = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    @(negedge clk); #1;
    check("busy_after_trigger", bus.busy, 1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    check("done_seen", done_cnt != 0, 1);
  endtask

  task automatic drop_load();
    @(posedge clk); #1;
    bus.data_load = 1'b0;
    wait_cycles(3);
  endtask

  task automatic run_full(input logic [AW-1:0] sa, input logic [AW-1:0] st, input int nb);
    clear_stats();
    push_expected(sa, st, nb, nb * BURST);
    start_run(sa, st, NB_W'(nb));
    wait_done(1000);
    wait_cycles(5);
    check("queue_drained", exp_q.size(), 0);
    check("rvalid_count", rv_cnt, nb * BURST);
    check("mem_ren_count", ren_cnt, nb * BURST);
    check("done_count", done_cnt, 1);
    check("busy_at_done", done_busy, 0);
    check("busy_after_run", bus.busy, 0);
    check("state_idle", bus.fsm_state, 0);
    if (nb > 0) begin
      check("first_rvalid_latency", first_rv - trig_cyc, 9);
      check("done_after_last_word", done_cyc - last_rv, 1);
      check("gap_count", gap_q.size(), nb - 1);
      while (gap_q.size() > 0) check("gap_len", gap_q.pop_front(), 9);
    end else begin
      check("zero_done_latency", done_cyc - trig_cyc, 2);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_mem_ren"}, bus.mem_ren, 0);
    check({pfx, "_mem_addr"}, bus.mem_addr, 0);
    check({pfx, "_rvalid"}, bus.rvalid, 0);
    check({pfx, "_rdata"}, bus.rdata, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.data_load = 1'b0;
    bus.start_addr = '0;
    bus.step = '0;
    bus.num_bursts = '0;
    bus.mem_rdata = '0;
`ifdef BURST_FEEDER_STALL_EN
    stall = 1'b0;
`endif
    clear_stats();
    wait_cycles(4);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(2);

    // basic: three bursts 0..31, 1..32, 2..33
    run_full(10'd0, 10'd1, 3);
    check("rdata_hold", bus.rdata, 33);
    drop_load();

    // wrap across 1023 -> 0
    run_full(10'd1000, 10'd16, 2);
    drop_load();

    // zero bursts
    run_full(10'd50, 10'd4, 0);
    drop_load();

    // abort on the 10th word of burst 0
    clear_stats();
    push_expected(10'd5, 10'd1, 2, 10);
    start_run(10'd5, 10'd1, 16'd2);
    for (int i = 0; i < 200 && rv_cnt < 10; i++) begin
      @(negedge clk); #1;
    end
    bus.data_load = 1'b0;
    wait_cycles(1);
    check("abort_busy_next", bus.busy, 0);
    check("abort_rvalid_next", bus.rvalid, 0);
    wait_cycles(80);
    check("abort_rvalid_count", rv_cnt, 10);
    check("abort_no_done", done_cnt, 0);
    check("abort_state_idle", bus.fsm_state, 0);
    check("abort_queue_drained", exp_q.size(), 0);
    run_full(10'd100, 10'd3, 1);
    drop_load();

    // reset during RD, data_load left high
    clear_stats();
    push_expected(10'd0, 10'd1, 2, 64);
    start_run(10'd0, 10'd1, 16'd2);
    for (int i = 0; i < 200 && rv_cnt < 5; i++) begin
      @(negedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    check_outputs_zero("midrun_reset");
    rst = 1'b0;
    clear_stats();
    wait_cycles(60);
    check("no_retrigger_rvalid", rv_cnt, 0);
    check("no_retrigger_mem_ren", ren_cnt, 0);
    check("no_retrigger_busy", bus.busy, 0);
    drop_load();
    run_full(10'd7, 10'd2, 1);
    drop_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
